// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FPU default widths, rounding bit positions and packed-result field helpers.
package fpu_pkg;
  localparam int EXP_W_DEF = 8;
  localparam int MAN_W_DEF = 23;
  localparam int S_POS = 0;
  localparam int R_POS = 1;
  localparam int G_POS = 2;
  localparam int LSB_POS = 3;
  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction
  function automatic int frac_off();
    return 0;
  endfunction
  function automatic int exp_off(input int man_w);
    return man_w;
  endfunction
  function automatic int sign_off(input int exp_w, input int man_w);
    return exp_w + man_w;
  endfunction
endpackage

// File: rtl/leading_one_detect.sv
// leading_one_detect: index of the most significant set bit of vec_i, plus an all-zero flag.
module leading_one_detect #(
  parameter int W = 28,
  localparam int IW = $clog2(W)
) (
  input  logic [W-1:0]  vec_i,
  output logic [IW-1:0] idx_o,
  output logic          zero_o
);
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < W; i++) if (vec_i[i]) idx_o = IW'(i);
  end
  assign zero_o = ~|vec_i;
endmodule

// File: rtl/fp_normalize_round.sv
// fp_normalize_round: 3-stage normalise + round-to-nearest-even stage with range flags.
// The pipeline advances as one unit whenever the output register is free or being drained.
module fp_normalize_round import fpu_pkg::*; #(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   raw_sign,
  input  logic [EXP_W-1:0]       raw_exponent,
  input  logic [MAN_W+4:0]       raw_mantissa,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   flag_overflow,
  output logic                   flag_underflow,
  output logic                   flag_inexact
);
  localparam int RAW_W = MAN_W + 5;
  localparam int NRM_W = RAW_W - 1;
  localparam int PW = $clog2(RAW_W);
  localparam int XW = EXP_W + 2;
  localparam int RES_W = 1 + EXP_W + MAN_W;
  localparam logic signed [XW-1:0] EMAX = XW'((1 << EXP_W) - 1);
  logic en;
  logic v1_q, v2_q, v3_q;
  logic s1_sign_q, s1_zero_q, s2_sign_q, s2_zero_q;
  logic [EXP_W-1:0] s1_exp_q;
  logic [RAW_W-1:0] s1_man_q, lsh;
  logic [PW-1:0] s1_p_q, p_d, sh;
  logic z_d;
  logic [NRM_W-1:0] nrm_d, nrm_q;
  logic signed [XW-1:0] exp2_d, exp2_q, exp3;
  logic rup;
  logic [MAN_W+1:0] mr;
  logic [RES_W-1:0] res_d, result_q;
  logic ovf_d, unf_d, inx_d, ovf_q, unf_q, inx_q;
  assign en = !(v3_q && !out_ready);
  assign in_ready = en;
  leading_one_detect #(.W(RAW_W)) u_lod (.vec_i(raw_mantissa), .idx_o(p_d), .zero_o(z_d));
  assign sh = PW'(RAW_W - 2) - s1_p_q;
  assign lsh = s1_man_q << sh;
  // a carry shifts right by one, folding the lost bit into sticky
  assign nrm_d = s1_man_q[RAW_W-1] ? {s1_man_q[RAW_W-1:2], |s1_man_q[1:0]} : lsh[NRM_W-1:0];
  assign exp2_d = s1_man_q[RAW_W-1] ? XW'(s1_exp_q) + XW'(1) : XW'(s1_exp_q) - XW'(sh);
  assign rup = nrm_q[G_POS] && (nrm_q[R_POS] || nrm_q[S_POS] || nrm_q[LSB_POS]);
  assign mr = {1'b0, nrm_q[NRM_W-1:LSB_POS]} + (MAN_W+2)'(rup);
  assign exp3 = exp2_q + XW'(mr[MAN_W+1]);
  always_comb begin
    res_d = {s2_sign_q, exp3[EXP_W-1:0], mr[MAN_W-1:0]};
    ovf_d = 1'b0;
    unf_d = 1'b0;
    inx_d = |nrm_q[G_POS:S_POS];
    if (s2_zero_q) begin
      res_d = '0;
      inx_d = 1'b0;
    end else if (exp3 >= EMAX) begin
      res_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ovf_d = 1'b1;
      inx_d = 1'b1;
    end else if (exp3 <= 0) begin
      res_d = {s2_sign_q, {(EXP_W+MAN_W){1'b0}}};
      unf_d = 1'b1;
      inx_d = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      s1_sign_q <= 1'b0;
      s1_zero_q <= 1'b0;
      s1_exp_q <= '0;
      s1_man_q <= '0;
      s1_p_q <= '0;
      s2_sign_q <= 1'b0;
      s2_zero_q <= 1'b0;
      nrm_q <= '0;
      exp2_q <= '0;
      result_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      inx_q <= 1'b0;
    end else if (en) begin
      v1_q <= in_valid;
      s1_sign_q <= raw_sign;
      s1_zero_q <= z_d;
      s1_exp_q <= raw_exponent;
      s1_man_q <= raw_mantissa;
      s1_p_q <= p_d;
      v2_q <= v1_q;
      s2_sign_q <= s1_sign_q && !s1_zero_q;
      s2_zero_q <= s1_zero_q;
      nrm_q <= nrm_d;
      exp2_q <= exp2_d;
      v3_q <= v2_q;
      result_q <= res_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      inx_q <= inx_d;
    end
  assign out_valid = v3_q;
  assign result = result_q;
  assign flag_overflow = ovf_q;
  assign flag_underflow = unf_q;
  assign flag_inexact = inx_q;
endmodule

// File: tb/tb_fp_normalize_round.sv
// tb_fp_normalize_round: directed and randomized checks against an arithmetic reference model.
module tb_fp_normalize_round;
  localparam int EW = 8, MW = 23, RW = MW + 5, RES = 1 + EW + MW;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, raw_sign = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, flag_overflow, flag_underflow, flag_inexact;
  logic [EW-1:0] raw_exponent = '0;
  logic [RW-1:0] raw_mantissa = '0;
  logic [RES-1:0] result, held;
  logic held_v = 1'b0;
  int checks = 0, errors = 0, cyc = 0, stalls = 0;
  typedef struct {logic [RES+2:0] v; int t; bit lat;} exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  fp_normalize_round #(.EXP_W(EW), .MAN_W(MW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .raw_sign(raw_sign), .raw_exponent(raw_exponent), .raw_mantissa(raw_mantissa),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .flag_overflow(flag_overflow), .flag_underflow(flag_underflow), .flag_inexact(flag_inexact)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
    checks++;
    if (obs !== req) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, req);
    end
  endtask
  // value-level model: normalise into [2^26, 2^27), round half to even on the 3 dropped bits
  function automatic logic [RES+2:0] model(input logic s, input int e, input longint m);
    longint keep, rem;
    int ee = e;
    if (m == 0) return '0;
    if (m >= (longint'(1) << (RW - 1))) begin
      m = (m >> 1) | (m & 1);
      ee++;
    end
    while (m < (longint'(1) << (RW - 2))) begin
      m = m << 1;
      ee--;
    end
    keep = m >> 3;
    rem = m & 7;
    if (rem > 4 || (rem == 4 && (keep % 2) == 1)) keep++;
    if (keep == (longint'(1) << (MW + 1))) begin
      keep = keep >> 1;
      ee++;
    end
    if (ee >= (1 << EW) - 1) return {s, {EW{1'b1}}, {MW{1'b0}}, 3'b101};
    if (ee <= 0) return {s, {(EW+MW){1'b0}}, 3'b011};
    return {s, EW'(ee), MW'(keep), 2'b00, rem != 0};
  endfunction
  task automatic step(input bit v, input bit s, input logic [EW-1:0] e, input logic [RW-1:0] m,
                      input bit ordy, input bit lat, input bit use_ex, input logic [RES+2:0] ex,
                      output bit acc);
    exp_t x;
    @(negedge clk);
    cyc++;
    in_valid = v;
    raw_sign = s;
    raw_exponent = e;
    raw_mantissa = m;
    out_ready = ordy;
    #1;
    chk("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
    if (!in_ready) stalls++;
    if (held_v && out_valid) chk("hold", 64'(result), 64'(held));
    held_v = out_valid && !out_ready;
    held = result;
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("spurious_out", 64'(out_valid), 64'(0));
      else begin
        x = q.pop_front();
        chk("result", 64'({result, flag_overflow, flag_underflow, flag_inexact}), 64'(x.v));
        if (x.lat) chk("latency", 64'(cyc - x.t), 64'(3));
      end
    end
    acc = v && in_ready;
    if (acc) begin
      x.v = use_ex ? ex : model(s, int'(e), longint'(m));
      x.t = cyc;
      x.lat = lat;
      q.push_back(x);
    end
  endtask
  task automatic idle(input int n);
    bit a;
    repeat (n) step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, '0, a);
  endtask
  logic [0:9] d_s = 10'b0000000110;
  logic [EW-1:0] d_e[10] = '{127, 127, 127, 127, 127, 254, 3, 100, 128, 127};
  logic [RW-1:0] d_m[10] = '{28'h4000000, 28'h8000000, 28'h0000008, 28'h4000004, 28'h400000C,
                             28'h8000000, 28'h0000100, 28'h0000000, 28'h4000000, 28'h7FFFFFC};
  logic [RES+2:0] d_x[10] = '{{32'h3F800000, 3'b000}, {32'h40000000, 3'b000}, {32'h34000000, 3'b000},
                              {32'h3F800000, 3'b001}, {32'h3F800002, 3'b001}, {32'h7F800000, 3'b101},
                              {32'h00000000, 3'b011}, {32'h00000000, 3'b000}, {32'hC0000000, 3'b000},
                              {32'h40000000, 3'b001}};
  logic b_s[8];
  logic [EW-1:0] b_e[8];
  logic [RW-1:0] b_m[8];
  initial begin
    bit acc;
    int idx;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_result", 64'(result), 64'(0));
    chk("rst_flags", 64'({flag_overflow, flag_underflow, flag_inexact}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    for (int i = 0; i < 10; i++) step(1'b1, d_s[i], d_e[i], d_m[i], 1'b1, 1'b1, 1'b1, d_x[i], acc);
    idle(6);
    chk("directed_drain", 64'(q.size()), 64'(0));
    for (int i = 0; i < 8; i++) begin
      b_s[i] = 1'($urandom);
      b_e[i] = EW'($urandom_range(1, 250));
      b_m[i] = RW'($urandom | 32'h0400_0000) ^ RW'(i);
    end
    idx = 0;
    stalls = 0;
    for (int c = 0; c < 30; c++) begin
      step(idx < 8, b_s[idx % 8], b_e[idx % 8], b_m[idx % 8], !(c >= 4 && c <= 7), 1'b0, 1'b0, '0, acc);
      if (acc) idx++;
    end
    chk("bp_accepted", 64'(idx), 64'(8));
    chk("bp_stall_seen", 64'(stalls > 0), 64'(1));
    chk("bp_drain", 64'(q.size()), 64'(0));
    for (int c = 0; c < 500; c++)
      step($urandom_range(0, 3) != 0, 1'($urandom), EW'($urandom_range(0, 255)),
           RW'($urandom >> $urandom_range(0, 31)), $urandom_range(0, 3) != 0, 1'b0, 1'b0, '0, acc);
    idle(8);
    chk("rand_drain", 64'(q.size()), 64'(0));
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'd127, 28'h4000000 + RW'(i << 3), 1'b1, 1'b0, 1'b0, '0, acc);
    @(negedge clk);
    cyc++;
    in_valid = 1'b0;
    #1;
    chk("pre_rst_valid", 64'(out_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'(0));
    chk("async_rst_result", 64'(result), 64'(0));
    q.delete();
    held_v = 1'b0;
    @(negedge clk);
    cyc++;
    rst_n = 1'b1;
    step(1'b1, 1'b0, 8'd127, 28'h8000000, 1'b1, 1'b1, 1'b1, {32'h40000000, 3'b000}, acc);
    idle(6);
    chk("post_rst_drain", 64'(q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_normalize_round.md
Name: fp_normalize_round

Overview:
- Parametrised, pipelined post-normalisation and rounding stage for the FPU datapath. Sits after the mantissa adder/multiplier core.
- Takes a raw sign, biased exponent and un-normalised extended mantissa, which carries a carry bit, a hidden bit, the fraction and G/R/S bits.
- Produces a packed IEEE-754-style result with round-to-nearest-even and overflow/underflow/inexact flags.
- Fully registered, 3-stage pipeline with valid/ready handshake on both sides.

Parameters:
- EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1)
- MAN_W, 23, stored fraction width (hidden bit excluded)
- RAW_W, MAN_W+5 (derived, localparam), raw mantissa width: [RAW_W-1]=carry, [RAW_W-2]=hidden, then MAN_W fraction, then G, R, S

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input operand valid
- in_ready  out  1  block accepts input this cycle
- raw_sign  in  1  sign of raw result
- raw_exponent  in  EXP_W  biased exponent before normalisation
- raw_mantissa  in  RAW_W  un-normalised extended mantissa
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- result  out  1+EXP_W+MAN_W  packed {sign, exponent, fraction}
- flag_overflow  out  1  result saturated to infinity
- flag_underflow  out  1  result flushed to zero
- flag_inexact  out  1  nonzero bits discarded by rounding

Behaviour:
- Reset (async, rst_n=0):
  - all pipeline valid bits = 0, so out_valid = 0.
  - result = 0 and all flags = 0.
  - in_ready is 1 once reset deasserts.
  - Reset mid-operation discards every in-flight item.
- Handshake:
  - Input transfer occurs when in_valid && in_ready; output transfer when out_valid && out_ready.
  - in_ready = !(out_valid && !out_ready). The whole pipeline stalls as one; no bubbles are collapsed.
  - Latency is exactly 3 cycles with no stall. Throughput is 1 per cycle.
  - Outputs hold stable while out_valid && !out_ready.
- Stage 1 registers the inputs and computes p = index of the leading one of raw_mantissa (leading-one detector).
- Stage 2 (normalise), using signed exponent arithmetic of width EXP_W+2:
  - p = RAW_W-1: right shift by 1, e = raw_exponent+1. The shifted-out bit is ORed into S.
  - p <= RAW_W-2: left shift by s = (RAW_W-2)-p, e = raw_exponent - s.
  - raw_mantissa = 0: result +0 (sign forced 0), exponent 0, no flags.
- Stage 3 (round, RNE):
  - lsb = normalised bit 3; G, R, S = bits 2, 1, 0.
  - round_up = G && (R || S || lsb).
  - flag_inexact = G || R || S.
  - If the fraction increment carries out of the hidden bit: e = e+1 and fraction = 0.
- Stage 3 (range, evaluated after rounding):
  - e >= 2^EXP_W-1: result = {sign, all-ones, 0}, flag_overflow = 1, flag_inexact = 1.
  - e <= 0: result = {sign, 0, 0}, flag_underflow = 1, flag_inexact = 1. No denormals are produced.
- Simultaneous events: an input accept and an output accept in the same cycle both occur. Ordering is strictly FIFO.

Decomposition:
- Shared package fpu_pkg: EXP_W/MAN_W defaults, bias constant, G/R/S bit-position constants, and packed-result field offsets.
- One sub-module: leading_one_detect (parameter W; input vector; outputs index and zero flag, combinational). Used in stage 1.

Test Plan (EXP_W=8, MAN_W=23, RAW_W=28):
1. Hidden-bit input: sign=0, exp=127, mant=28'h4000000 -> result 32'h3F800000 exactly 3 cycles after accept; all flags 0.
2. Carry input: exp=127, mant=28'h8000000 -> 32'h40000000. Deep left shift: exp=127, mant=28'h0000008 -> 32'h34000000.
3. RNE rounding:
   - exp=127, mant=28'h4000004 (tie, even lsb) -> 32'h3F800000, inexact=1.
   - mant=28'h400000C (tie, odd lsb) -> 32'h3F800002, inexact=1.
4. Range limits:
   - exp=254, mant=28'h8000000 -> 32'h7F800000, overflow=1.
   - exp=3, mant=28'h0000100 -> 32'h00000000, underflow=1.
   - mant=0, sign=1 -> 32'h00000000, flags 0.
5. Backpressure: stream 8 distinct operands with out_ready low for cycles 4-7 -> in_ready drops, no loss or duplication, outputs in order, result held stable while stalled.
6. Reset mid-stream: assert rst_n=0 with 3 items in flight -> out_valid=0 immediately (async). After release, the first new operand appears 3 cycles after accept.
